viterbi_pmu_ctrl: RTL and testbench

- Path-metric unit and frame sequencer for the 4-state Viterbi decoder.
- Holds the four registered path metrics and drives them into the combinational add-compare-select unit.
- Captures the unit's new metrics and 4-bit decision vector once per accepted symbol, and normalizes the metrics to prevent saturation drift.
- Streams decision vectors with addresses to traceback memory. At frame end, reports the best (minimum-metric) final state.

---
 rtl/viterbi_pkg.sv | 19 +
 rtl/pm_min4.sv | 40 ++++
 rtl/viterbi_pmu_ctrl.sv | 141 ++++++++++++++
 tb/tb_viterbi_pmu_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants and FSM encoding for the 4-state Viterbi decoder blocks.
package viterbi_pkg;

    localparam int NUM_STATES   = 4;
    localparam int PM_WIDTH_DEF = 8;

    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } pmu_state_t;

endpackage

// File: rtl/pm_min4.sv
// Four-input unsigned minimum with 2-bit argmin; ties go to the lower index.
module pm_min4
    import viterbi_pkg::*;
#(
    parameter int PM_WIDTH = PM_WIDTH_DEF
) (
    input  logic [PM_WIDTH-1:0] a0,
    input  logic [PM_WIDTH-1:0] a1,
    input  logic [PM_WIDTH-1:0] a2,
    input  logic [PM_WIDTH-1:0] a3,
    output logic [PM_WIDTH-1:0] min_val,
    output logic [1:0]          min_idx
);

    logic [PM_WIDTH-1:0] lo_val, hi_val;
    logic [1:0]          lo_idx, hi_idx;

    // Strict less-than at every stage keeps the lower index on ties.
    always_comb begin
        lo_val = a0;
        lo_idx = S0;
        if (a1 < a0) begin
            lo_val = a1;
            lo_idx = S1;
        end
        hi_val = a2;
        hi_idx = S2;
        if (a3 < a2) begin
            hi_val = a3;
            hi_idx = S3;
        end
        min_val = lo_val;
        min_idx = lo_idx;
        if (hi_val < lo_val) begin
            min_val = hi_val;
            min_idx = hi_idx;
        end
    end

endmodule

// File: rtl/viterbi_pmu_ctrl.sv
// Path-metric registers, metric normalization, decision-word streaming and
// frame sequencing for the 4-state Viterbi decoder.
module viterbi_pmu_ctrl
    import viterbi_pkg::*;
#(
    parameter int PM_WIDTH    = PM_WIDTH_DEF,
    parameter int FRAME_LEN   = 64,
    parameter int CNT_WIDTH   = 8,
    parameter int INIT_PM     = 64,
    parameter int NORM_THRESH = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 sym_valid_i,
    output logic                 sym_ready_o,
    input  logic [PM_WIDTH-1:0]  acs_pm_s0_i,
    input  logic [PM_WIDTH-1:0]  acs_pm_s1_i,
    input  logic [PM_WIDTH-1:0]  acs_pm_s2_i,
    input  logic [PM_WIDTH-1:0]  acs_pm_s3_i,
    input  logic [3:0]           acs_dec_i,
    output logic [PM_WIDTH-1:0]  pm_s0_o,
    output logic [PM_WIDTH-1:0]  pm_s1_o,
    output logic [PM_WIDTH-1:0]  pm_s2_o,
    output logic [PM_WIDTH-1:0]  pm_s3_o,
    output logic                 dec_valid_o,
    input  logic                 dec_ready_i,
    output logic [3:0]           dec_bits_o,
    output logic [CNT_WIDTH-1:0] dec_addr_o,
    output logic                 frame_done_o,
    output logic [1:0]           best_state_o,
    output logic                 busy_o
);

    localparam logic [CNT_WIDTH-1:0] LAST_SYM = CNT_WIDTH'(FRAME_LEN - 1);
    localparam logic [PM_WIDTH-1:0]  PM_INIT  = PM_WIDTH'(INIT_PM);
    localparam logic [PM_WIDTH-1:0]  PM_NORM  = PM_WIDTH'(NORM_THRESH);

    pmu_state_t           state;
    logic [CNT_WIDTH-1:0] cnt;

    logic [PM_WIDTH-1:0]  acs_min;
    logic [1:0]           norm_idx_unused;
    logic [PM_WIDTH-1:0]  best_min_unused;
    logic [1:0]           best_idx;
    logic [PM_WIDTH-1:0]  norm_sub;
    logic [PM_WIDTH-1:0]  npm_s0, npm_s1, npm_s2, npm_s3;
    logic                 accept;
    logic                 out_fire;

    pm_min4 #(.PM_WIDTH(PM_WIDTH)) u_norm_min (
        .a0      (acs_pm_s0_i),
        .a1      (acs_pm_s1_i),
        .a2      (acs_pm_s2_i),
        .a3      (acs_pm_s3_i),
        .min_val (acs_min),
        .min_idx (norm_idx_unused)
    );

    pm_min4 #(.PM_WIDTH(PM_WIDTH)) u_best_min (
        .a0      (pm_s0_o),
        .a1      (pm_s1_o),
        .a2      (pm_s2_o),
        .a3      (pm_s3_o),
        .min_val (best_min_unused),
        .min_idx (best_idx)
    );

    // Subtracting the minimum itself can never underflow any operand.
    assign norm_sub = (acs_min >= PM_NORM) ? acs_min : '0;
    assign npm_s0   = acs_pm_s0_i - norm_sub;
    assign npm_s1   = acs_pm_s1_i - norm_sub;
    assign npm_s2   = acs_pm_s2_i - norm_sub;
    assign npm_s3   = acs_pm_s3_i - norm_sub;

    // One-entry output slot: may refill on the same edge it drains.
    assign sym_ready_o = (state == RUN) && (!dec_valid_o || dec_ready_i);
    assign accept      = sym_valid_i && sym_ready_o;
    assign out_fire    = dec_valid_o && dec_ready_i;
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= IDLE;
            cnt          <= '0;
            pm_s0_o      <= '0;
            pm_s1_o      <= '0;
            pm_s2_o      <= '0;
            pm_s3_o      <= '0;
            dec_valid_o  <= 1'b0;
            dec_bits_o   <= '0;
            dec_addr_o   <= '0;
            frame_done_o <= 1'b0;
            best_state_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        pm_s0_o <= '0;
                        pm_s1_o <= PM_INIT;
                        pm_s2_o <= PM_INIT;
                        pm_s3_o <= PM_INIT;
                        cnt     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        pm_s0_o     <= npm_s0;
                        pm_s1_o     <= npm_s1;
                        pm_s2_o     <= npm_s2;
                        pm_s3_o     <= npm_s3;
                        dec_bits_o  <= acs_dec_i;
                        dec_addr_o  <= cnt;
                        dec_valid_o <= 1'b1;
                        cnt         <= cnt + 1'b1;
                        if (cnt == LAST_SYM)
                            state <= DRAIN;
                    end else if (out_fire) begin
                        dec_valid_o <= 1'b0;
                    end
                end
                DRAIN: begin
                    best_state_o <= best_idx;
                    if (out_fire)
                        dec_valid_o <= 1'b0;
                    if (!dec_valid_o || dec_ready_i) begin
                        frame_done_o <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    frame_done_o <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_pmu_ctrl.sv
// Directed self-checking bench for viterbi_pmu_ctrl with a 4-symbol frame.
module tb_viterbi_pmu_ctrl;

    localparam int PW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic          sym_valid_i;
    logic          sym_ready_o;
    logic [PW-1:0] acs_pm_s0_i, acs_pm_s1_i, acs_pm_s2_i, acs_pm_s3_i;
    logic [3:0]    acs_dec_i;
    logic [PW-1:0] pm_s0_o, pm_s1_o, pm_s2_o, pm_s3_o;
    logic          dec_valid_o;
    logic          dec_ready_i;
    logic [3:0]    dec_bits_o;
    logic [CW-1:0] dec_addr_o;
    logic          frame_done_o;
    logic [1:0]    best_state_o;
    logic          busy_o;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    viterbi_pmu_ctrl #(
        .PM_WIDTH(PW), .FRAME_LEN(4), .CNT_WIDTH(CW), .INIT_PM(64), .NORM_THRESH(128)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
        .sym_valid_i(sym_valid_i), .sym_ready_o(sym_ready_o),
        .acs_pm_s0_i(acs_pm_s0_i), .acs_pm_s1_i(acs_pm_s1_i),
        .acs_pm_s2_i(acs_pm_s2_i), .acs_pm_s3_i(acs_pm_s3_i),
        .acs_dec_i(acs_dec_i),
        .pm_s0_o(pm_s0_o), .pm_s1_o(pm_s1_o), .pm_s2_o(pm_s2_o), .pm_s3_o(pm_s3_o),
        .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
        .dec_bits_o(dec_bits_o), .dec_addr_o(dec_addr_o),
        .frame_done_o(frame_done_o), .best_state_o(best_state_o), .busy_o(busy_o)
    );

    always @(negedge clk) if (frame_done_o) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pm(input string tag, input int e0, input int e1, input int e2, input int e3);
        chk({tag, "_pm0"}, 32'(pm_s0_o), 32'(e0));
        chk({tag, "_pm1"}, 32'(pm_s1_o), 32'(e1));
        chk({tag, "_pm2"}, 32'(pm_s2_o), 32'(e2));
        chk({tag, "_pm3"}, 32'(pm_s3_o), 32'(e3));
    endtask

    task automatic drive_sym(input int p0, input int p1, input int p2, input int p3, input logic [3:0] d);
        sym_valid_i = 1'b1;
        acs_pm_s0_i = PW'(p0);
        acs_pm_s1_i = PW'(p1);
        acs_pm_s2_i = PW'(p2);
        acs_pm_s3_i = PW'(p3);
        acs_dec_i   = d;
    endtask

    initial begin
        rst_ni = 1'b0; start_i = 1'b0; sym_valid_i = 1'b0; dec_ready_i = 1'b0;
        acs_pm_s0_i = '0; acs_pm_s1_i = '0; acs_pm_s2_i = '0; acs_pm_s3_i = '0;
        acs_dec_i = '0;
        repeat (3) step();
        chk_pm("rst", 0, 0, 0, 0);
        chk("rst_dvalid", 32'(dec_valid_o), 0);
        chk("rst_dbits", 32'(dec_bits_o), 0);
        chk("rst_daddr", 32'(dec_addr_o), 0);
        chk("rst_done", 32'(frame_done_o), 0);
        chk("rst_best", 32'(best_state_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_ready", 32'(sym_ready_o), 0);

        rst_ni = 1'b1;
        step();
        chk("idle_busy", 32'(busy_o), 0);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk_pm("start", 0, 64, 64, 64);
        chk("start_busy", 32'(busy_o), 1);

        // Symbol 0: no normalization.
        dec_ready_i = 1'b1;
        drive_sym(10, 20, 30, 40, 4'b1010);
        #1 chk("s0_ready", 32'(sym_ready_o), 1);
        step();
        chk_pm("s0", 10, 20, 30, 40);
        chk("s0_dbits", 32'(dec_bits_o), 4'b1010);
        chk("s0_daddr", 32'(dec_addr_o), 0);
        chk("s0_dvalid", 32'(dec_valid_o), 1);

        // Backpressure: slot full and not draining.
        sym_valid_i = 1'b0;
        dec_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_ready", 32'(sym_ready_o), 0);
            step();
            chk("bp_dbits", 32'(dec_bits_o), 4'b1010);
            chk("bp_daddr", 32'(dec_addr_o), 0);
            chk("bp_dvalid", 32'(dec_valid_o), 1);
        end

        // Drain and refill on one edge, with normalization (min 130).
        dec_ready_i = 1'b1;
        drive_sym(130, 140, 135, 255, 4'b0101);
        #1 chk("refill_ready", 32'(sym_ready_o), 1);
        step();
        chk_pm("norm", 0, 10, 5, 125);
        chk("norm_daddr", 32'(dec_addr_o), 1);
        chk("norm_dbits", 32'(dec_bits_o), 4'b0101);
        chk("norm_dvalid", 32'(dec_valid_o), 1);

        // Min 127 is below threshold: stored unchanged.
        drive_sym(127, 200, 200, 200, 4'b0011);
        step();
        chk_pm("nonorm", 127, 200, 200, 200);
        chk("nonorm_daddr", 32'(dec_addr_o), 2);

        // Last symbol of the frame.
        drive_sym(7, 3, 3, 9, 4'b1100);
        step();
        sym_valid_i = 1'b0;
        chk_pm("last", 7, 3, 3, 9);
        chk("last_daddr", 32'(dec_addr_o), 3);
        chk("last_dvalid", 32'(dec_valid_o), 1);
        chk("drain_ready", 32'(sym_ready_o), 0);
        chk("drain_busy", 32'(busy_o), 1);
        chk("drain_done", 32'(frame_done_o), 0);
        step();
        chk("done_pulse", 32'(frame_done_o), 1);
        chk("done_best", 32'(best_state_o), 1);
        chk("done_dvalid", 32'(dec_valid_o), 0);
        chk("done_busy", 32'(busy_o), 1);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("post_done", 32'(frame_done_o), 0);
        chk("post_busy", 32'(busy_o), 0);
        chk("post_best", 32'(best_state_o), 1);
        chk_pm("post", 7, 3, 3, 9);
        step();
        chk("ignored_start_busy", 32'(busy_o), 0);
        chk("done_count", 32'(done_cnt), 1);

        // Second frame aborted by reset after two accepts.
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        dec_ready_i = 1'b0;
        drive_sym(1, 2, 3, 4, 4'b0001);
        step();
        dec_ready_i = 1'b1;
        drive_sym(5, 6, 7, 8, 4'b0010);
        step();
        dec_ready_i = 1'b0;
        sym_valid_i = 1'b0;
        chk("abort_pre_dvalid", 32'(dec_valid_o), 1);
        chk("abort_pre_daddr", 32'(dec_addr_o), 1);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        chk("abort_dvalid", 32'(dec_valid_o), 0);
        chk("abort_busy", 32'(busy_o), 0);
        chk("abort_daddr", 32'(dec_addr_o), 0);
        chk_pm("abort", 0, 0, 0, 0);
        repeat (8) step();
        chk("abort_done_count", 32'(done_cnt), 1);
        chk("abort_idle_busy", 32'(busy_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
